// File: rtl/rx_ctrl_pkg.sv
// Shared state encoding and default frame geometry for the serial receive controller.
package rx_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int CLKS_PER_BIT_DEF  = 10;
  localparam int NUM_DATA_BITS_DEF = 8;

endpackage

// File: rtl/rx_bit_timer.sv
// Up-counter that returns to zero after reaching rollover_val; flag marks the terminal count.
module rx_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      if (r_count == rollover_val) r_count <= '0;
      else                         r_count <= r_count + WIDTH'(1);
    end
  end

  assign count         = r_count;
  assign rollover_flag = (r_count == rollover_val);

endmodule

// File: rtl/rx_sr_controller.sv
// Receive sequencer: synchronises the line, finds the start bit and paces shift_enable at mid-bit.
// state | meaning: IDLE wait for edge | START confirm start at half bit | DATA one shift per bit | STOP check stop bit
module rx_sr_controller
  import rx_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
  parameter int NUM_DATA_BITS = NUM_DATA_BITS_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  output logic sr_serial,
  output logic shift_enable,
  output logic data_ready,
  output logic framing_error,
  output logic rx_busy
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(NUM_DATA_BITS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [TW-1:0] TC_HALF  = TW'(HALF - 1);
  localparam logic [TW-1:0] TC_BIT   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_DONE = BW'(NUM_DATA_BITS);

  logic      r_sync_q1;
  logic      r_sync_q2;
  logic      r_prev;
  rx_state_t r_state;
  rx_state_t w_next_state;
  logic      r_framing_error;
  logic      w_fe_next;
  logic      w_start_edge;
  logic      w_shift_enable;
  logic      w_data_ready;

  logic          w_timer_clear;
  logic          w_timer_en;
  logic [TW-1:0] w_timer_rollover;
  logic [TW-1:0] w_timer;
  logic          w_timer_tc;
  logic [BW-1:0] w_bit_cnt;
  logic          w_bits_done;

  // Idle-high reset values keep a reset release from looking like a start edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync_q1 <= 1'b1;
      r_sync_q2 <= 1'b1;
      r_prev    <= 1'b1;
    end else begin
      r_sync_q1 <= serial_in;
      r_sync_q2 <= r_sync_q1;
      r_prev    <= r_sync_q2;
    end
  end

  assign w_start_edge = r_prev & ~r_sync_q2;

  assign w_timer_clear    = (r_state == IDLE);
  assign w_timer_en       = (r_state != IDLE);
  assign w_timer_rollover = (r_state == START) ? TC_HALF : TC_BIT;

  rx_bit_timer #(.WIDTH(TW)) u_bit_period (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_timer_clear),
    .count_enable (w_timer_en),
    .rollover_val (w_timer_rollover),
    .count        (w_timer),
    .rollover_flag(w_timer_tc)
  );

  rx_bit_timer #(.WIDTH(BW)) u_bit_count (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_timer_clear),
    .count_enable (w_shift_enable),
    .rollover_val (BIT_DONE),
    .count        (w_bit_cnt),
    .rollover_flag(w_bits_done)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= IDLE;
      r_framing_error <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_framing_error <= w_fe_next;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_fe_next      = r_framing_error;
    w_shift_enable = 1'b0;
    w_data_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_next_state = START;
          w_fe_next    = 1'b0;
        end
      end
      START: begin
        if (w_timer_tc) w_next_state = r_sync_q2 ? IDLE : DATA;
      end
      DATA: begin
        if (w_timer_tc) begin
          w_shift_enable = 1'b1;
          if (w_bit_cnt == BIT_LAST) w_next_state = STOP;
        end
      end
      STOP: begin
        if (w_timer_tc) begin
          w_next_state = IDLE;
          if (r_sync_q2 && w_bits_done) w_data_ready = 1'b1;
          else                          w_fe_next    = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign sr_serial     = r_sync_q2;
  assign shift_enable  = w_shift_enable;
  assign data_ready    = w_data_ready;
  assign framing_error = r_framing_error;
  assign rx_busy       = (r_state != IDLE);

endmodule
